// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//   Sequences the shared pipelined complex MAC of the 4x4 complex matrix
//   multiplier C = A*B. A Start pulse launches 64 operand issues (k innermost,
//   then j, then i), the first term of every C element clears the accumulator,
//   and row-major C write strobes follow each element's last term after the
//   MAC pipeline delay. Busy / Done / DoneFlag / StartIgnored give status.
//
// Ports
//   Clk, Reset        clock (rising edge), asynchronous active-high reset
//   Start, Abort      single-cycle start pulse, synchronous abort
//   IdxI/IdxJ/IdxK    operand indices of the current issue (0 when idle)
//   MacEn, AccClr     issue valid, first-term (load instead of accumulate)
//   WrEn, WrRow/WrCol C write strobe and target element
//   Busy              run in progress (issue or drain)
//   Done              one-cycle pulse after the final C write
//   DoneFlag          sticky done
//   StartIgnored      sticky: Start seen while Busy
// -----------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int unsigned MAC_LATENCY = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  output logic [1:0] IdxI,
  output logic [1:0] IdxJ,
  output logic [1:0] IdxK,
  output logic       MacEn,
  output logic       AccClr,
  output logic       WrEn,
  output logic [1:0] WrRow,
  output logic [1:0] WrCol,
  output logic       Busy,
  output logic       Done,
  output logic       DoneFlag,
  output logic       StartIgnored
);

  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 3 * IDX_W;
  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Tag carried alongside each issue through the MAC-delay pipeline
  typedef struct packed {
    logic             last;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } wr_tag_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;        // {i, j, k}, k in the LSBs
  logic [DRAIN_W-1:0] drain_q, drain_d;
  wr_tag_t            pipe_q [MAC_LATENCY];
  wr_tag_t            pipe_in_c;
  logic               done_q, done_flag_q, done_flag_d;
  logic               start_ign_q, start_ign_d;

  logic issue_c, accept_c, finish_c, issue_last_c, start_busy_c;

  assign issue_c      = (state_q == S_ISSUE);
  assign issue_last_c = (idx_q == CNT_W'(6'h3f));
  // Abort always wins over Start, so a Start in the abort cycle is neither run nor flagged
  assign accept_c     = (state_q == S_IDLE) && Start && !Abort;
  assign start_busy_c = (state_q != S_IDLE) && Start && !Abort;
  assign finish_c     = (state_q == S_DRAIN) && !Abort && (drain_q == '0);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (Abort)             state_d = S_IDLE;
        else if (issue_last_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (Abort || (drain_q == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; indices are forced to 0 outside issue cycles
  always_comb begin
    MacEn  = 1'b0;
    AccClr = 1'b0;
    IdxI   = '0;
    IdxJ   = '0;
    IdxK   = '0;
    Busy   = 1'b0;
    case (state_q)
      S_ISSUE: begin
        MacEn  = 1'b1;
        IdxI   = idx_q[5:4];
        IdxJ   = idx_q[3:2];
        IdxK   = idx_q[1:0];
        AccClr = (idx_q[1:0] == '0);
        Busy   = 1'b1;
      end
      S_DRAIN: Busy = 1'b1;
      default: ;
    endcase
  end

  // Counter, drain and status next values
  always_comb begin
    idx_d       = idx_q;
    drain_d     = drain_q;
    done_flag_d = done_flag_q;
    start_ign_d = start_ign_q;
    pipe_in_c   = '0;

    if (accept_c)     idx_d = '0;
    else if (issue_c) idx_d = idx_q + CNT_W'(1);   // wraps to 0 after (3,3,3)

    // Drain counts MAC_LATENCY-1 down to 0, giving MAC_LATENCY drain cycles
    if (issue_c && issue_last_c)
      drain_d = DRAIN_W'(MAC_LATENCY - 1);
    else if ((state_q == S_DRAIN) && (drain_q != '0))
      drain_d = drain_q - DRAIN_W'(1);

    if (Abort)         done_flag_d = 1'b0;
    else if (finish_c) done_flag_d = 1'b1;
    else if (accept_c) done_flag_d = 1'b0;

    if (accept_c)          start_ign_d = 1'b0;
    else if (start_busy_c) start_ign_d = 1'b1;

    if (issue_c) begin
      pipe_in_c.last = (idx_q[1:0] == 2'd3);
      pipe_in_c.row  = idx_q[5:4];
      pipe_in_c.col  = idx_q[3:2];
    end
  end

  // Datapath registers; Abort flushes the write pipeline so no stale WrEn follows
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q       <= '0;
      drain_q     <= '0;
      done_q      <= 1'b0;
      done_flag_q <= 1'b0;
      start_ign_q <= 1'b0;
      for (int unsigned s = 0; s < MAC_LATENCY; s++) pipe_q[s] <= '0;
    end else begin
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      done_q      <= finish_c;
      done_flag_q <= done_flag_d;
      start_ign_q <= start_ign_d;
      if (Abort) begin
        for (int unsigned s = 0; s < MAC_LATENCY; s++) pipe_q[s] <= '0;
      end else begin
        pipe_q[0] <= pipe_in_c;
        for (int unsigned s = 1; s < MAC_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign WrEn         = pipe_q[MAC_LATENCY-1].last;
  assign WrRow        = WrEn ? pipe_q[MAC_LATENCY-1].row : '0;
  assign WrCol        = WrEn ? pipe_q[MAC_LATENCY-1].col : '0;
  assign Done         = done_q;
  assign DoneFlag     = done_flag_q;
  assign StartIgnored = start_ign_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer: two instances (MAC_LATENCY 3 and 1), a
// scoreboard of expected issue / write / done events checked by a monitor,
// and a behavioural complex MAC on the latency-3 instance.
module tb_matmul_sequencer;

  localparam int BIG = 32'h7fffffff;

  int lat [2] = '{3, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start_r, abort_r;
  logic [1:0] mac_en, acc_clr, wr_en, busy, done, done_flag, start_ign;
  logic [3:0] idx_i, idx_j, idx_k, wr_row, wr_col;

  matmul_sequencer #(.MAC_LATENCY(3)) u_dut3 (
    .Clk(clk), .Reset(rst), .Start(start_r[0]), .Abort(abort_r[0]),
    .IdxI(idx_i[1:0]), .IdxJ(idx_j[1:0]), .IdxK(idx_k[1:0]),
    .MacEn(mac_en[0]), .AccClr(acc_clr[0]),
    .WrEn(wr_en[0]), .WrRow(wr_row[1:0]), .WrCol(wr_col[1:0]),
    .Busy(busy[0]), .Done(done[0]), .DoneFlag(done_flag[0]),
    .StartIgnored(start_ign[0])
  );

  matmul_sequencer #(.MAC_LATENCY(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .Start(start_r[1]), .Abort(abort_r[1]),
    .IdxI(idx_i[3:2]), .IdxJ(idx_j[3:2]), .IdxK(idx_k[3:2]),
    .MacEn(mac_en[1]), .AccClr(acc_clr[1]),
    .WrEn(wr_en[1]), .WrRow(wr_row[3:2]), .WrCol(wr_col[3:2]),
    .Busy(busy[1]), .Done(done[1]), .DoneFlag(done_flag[1]),
    .StartIgnored(start_ign[1])
  );

  typedef struct {
    int cyc;
    int v;
  } ev_t;

  ev_t iss_q [2][$];
  ev_t wr_q  [2][$];
  ev_t dn_q  [2][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle=%0d got=%0h expected=%0h", name, d, cyc, act, exp);
    end
  endfunction

  function automatic void extra(string name, int d);
    total++;
    bad++;
    $display("FAIL %s dut%0d cycle=%0d got=event expected=none", name, d, cyc);
  endfunction

  function automatic logic [16:0] outs(int d);
    return {mac_en[d], acc_clr[d], idx_i[2*d +: 2], idx_j[2*d +: 2], idx_k[2*d +: 2],
            wr_en[d], wr_row[2*d +: 2], wr_col[2*d +: 2],
            busy[d], done[d], done_flag[d], start_ign[d]};
  endfunction

  // Expected events of a run started at t0; events after 'cut' are not expected
  function automatic void push_run(int d, int t0, int cut);
    ev_t e;
    for (int n = 0; n < 64; n++) begin
      e.cyc = t0 + 1 + n;
      e.v   = (n / 16) * 32 + ((n / 4) % 4) * 8 + (n % 4) * 2 + ((n % 4) == 0 ? 1 : 0);
      if (e.cyc <= cut) iss_q[d].push_back(e);
    end
    for (int el = 0; el < 16; el++) begin
      e.cyc = t0 + 4 * el + 4 + lat[d];
      e.v   = el;
      if (e.cyc <= cut) wr_q[d].push_back(e);
    end
    e.cyc = t0 + 65 + lat[d];
    e.v   = 0;
    if (e.cyc <= cut) dn_q[d].push_back(e);
  endfunction

  // Behavioural complex MAC attached to the latency-3 instance
  int a_re [4][4], a_im [4][4], b_re [4][4], b_im [4][4], c_re [4][4], c_im [4][4];
  int s1_re, s1_im, s2_re, s2_im, acc_re, acc_im;
  bit s1_v, s1_clr, s2_v, s2_clr;

  always @(posedge clk) begin
    s1_v   <= mac_en[0];
    s1_clr <= acc_clr[0];
    s1_re  <= a_re[idx_i[1:0]][idx_k[1:0]] * b_re[idx_k[1:0]][idx_j[1:0]]
            - a_im[idx_i[1:0]][idx_k[1:0]] * b_im[idx_k[1:0]][idx_j[1:0]];
    s1_im  <= a_re[idx_i[1:0]][idx_k[1:0]] * b_im[idx_k[1:0]][idx_j[1:0]]
            + a_im[idx_i[1:0]][idx_k[1:0]] * b_re[idx_k[1:0]][idx_j[1:0]];
    s2_v   <= s1_v;
    s2_clr <= s1_clr;
    s2_re  <= s1_re;
    s2_im  <= s1_im;
    if (s2_v) begin
      acc_re <= s2_clr ? s2_re : acc_re + s2_re;
      acc_im <= s2_clr ? s2_im : acc_im + s2_im;
    end
  end

  // Monitor: pop and compare on every DUT event
  ev_t mon_e;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mac_en[d]) begin
        if (iss_q[d].size() == 0) extra("issue_extra", d);
        else begin
          mon_e = iss_q[d].pop_front();
          chk("issue_cycle", d, cyc, mon_e.cyc);
          chk("issue_ijk_clr", d, {idx_i[2*d +: 2], idx_j[2*d +: 2], idx_k[2*d +: 2], acc_clr[d]}, mon_e.v);
        end
      end else begin
        chk("idle_idx", d, {idx_i[2*d +: 2], idx_j[2*d +: 2], idx_k[2*d +: 2], acc_clr[d]}, 0);
      end
      if (wr_en[d]) begin
        if (wr_q[d].size() == 0) extra("write_extra", d);
        else begin
          mon_e = wr_q[d].pop_front();
          chk("write_cycle", d, cyc, mon_e.cyc);
          chk("write_rowcol", d, {wr_row[2*d +: 2], wr_col[2*d +: 2]}, mon_e.v);
        end
      end
      if (done[d]) begin
        if (dn_q[d].size() == 0) extra("done_extra", d);
        else begin
          mon_e = dn_q[d].pop_front();
          chk("done_cycle", d, cyc, mon_e.cyc);
        end
      end
    end
    if (wr_en[0]) begin
      c_re[wr_row[1:0]][wr_col[1:0]] = acc_re;
      c_im[wr_row[1:0]][wr_col[1:0]] = acc_im;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic run_full(int d, int ign);
    int t0;
    start_r[d] = 1'b1;
    t0 = cyc;
    push_run(d, t0, BIG);
    tick();
    start_r[d] = 1'b0;
    chk("busy_first", d, busy[d], 1);
    chk("startign_clear", d, start_ign[d], 0);
    if (ign > 0) begin
      wait_cyc(t0 + ign);
      start_r[d] = 1'b1;
      tick();
      start_r[d] = 1'b0;
      chk("startign_set", d, start_ign[d], 1);
    end
    wait_cyc(t0 + 64 + lat[d]);
    chk("busy_last", d, {busy[d], done[d], done_flag[d]}, 3'b100);
    tick();
    chk("done_cycle_status", d, {busy[d], done[d], done_flag[d]}, 3'b011);
  endtask

  task automatic abort_test(int d);
    int t0;
    start_r[d] = 1'b1;
    t0 = cyc;
    push_run(d, t0, t0 + 20);
    tick();
    start_r[d] = 1'b0;
    wait_cyc(t0 + 20);
    start_r[d] = 1'b1;
    abort_r[d] = 1'b1;
    tick();
    start_r[d] = 1'b0;
    abort_r[d] = 1'b0;
    chk("abort_status", d, {busy[d], done_flag[d], start_ign[d]}, 3'b000);
    repeat (80) tick();
    chk("abort_quiet", d, {busy[d], done_flag[d]}, 2'b00);
  endtask

  task automatic b2b(int d);
    int t0, t1;
    start_r[d] = 1'b1;
    t0 = cyc;
    push_run(d, t0, BIG);
    tick();
    start_r[d] = 1'b0;
    wait_cyc(t0 + 65 + lat[d]);
    chk("b2b_done1", d, {done[d], done_flag[d]}, 2'b11);
    start_r[d] = 1'b1;
    t1 = cyc;
    push_run(d, t1, BIG);
    tick();
    start_r[d] = 1'b0;
    chk("b2b_restart", d, {busy[d], done[d], done_flag[d]}, 3'b100);
    wait_cyc(t1 + 65 + lat[d]);
    chk("b2b_done2", d, {busy[d], done[d], done_flag[d]}, 3'b011);
    tick();
    chk("done_one_cycle", d, {done[d], done_flag[d]}, 2'b01);
    abort_r[d] = 1'b1;
    tick();
    abort_r[d] = 1'b0;
    chk("idle_abort_flag", d, {busy[d], done_flag[d]}, 2'b00);
  endtask

  initial begin
    start_r = '0;
    abort_r = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a_re[r][c] = (r == c) ? 1 : 0;
        a_im[r][c] = 0;
        b_re[r][c] = r * 4 + c;
        b_im[r][c] = r - c;
        c_re[r][c] = 0;
        c_im[r][c] = 0;
      end
    end

    repeat (3) tick();
    for (int d = 0; d < 2; d++) chk("reset_outputs", d, outs(d), 0);
    rst = 1'b0;
    tick();

    // Run interrupted by an asynchronous mid-cycle reset
    start_r = 2'b11;
    push_run(0, cyc, BIG);
    push_run(1, cyc, BIG);
    tick();
    start_r = 2'b00;
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_midrun", d, outs(d), 0);
      iss_q[d].delete();
      wr_q[d].delete();
      dn_q[d].delete();
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();

    // Nominal run with the behavioural MAC: identity * B must equal B
    run_full(0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk("c_equals_b", 0, {32'(c_re[r][c]), 32'(c_im[r][c])}, {32'(b_re[r][c]), 32'(b_im[r][c])});

    run_full(0, 30);
    abort_test(0);
    b2b(0);

    run_full(1, 0);
    run_full(1, 30);
    abort_test(1);
    b2b(1);

    repeat (20) tick();
    for (int d = 0; d < 2; d++)
      chk("pending_events", d, iss_q[d].size() + wr_q[d].size() + dn_q[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
